// File: rtl/sisc_pkg.sv
// sisc_pkg: constants and types shared across the SISC fetch stage.
//   - opcode encodings carried in ir[31:28]
//   - bit positions of the opcode, mm and imm fields in an instruction word
//   - fetch handshake state enum
package sisc_pkg;

    localparam logic [3:0] OP_NOOP   = 4'd0;
    localparam logic [3:0] OP_LOD    = 4'd1;
    localparam logic [3:0] OP_STR    = 4'd2;
    localparam logic [3:0] OP_SWP    = 4'd3;
    localparam logic [3:0] OP_BRA    = 4'd4;
    localparam logic [3:0] OP_BRR    = 4'd5;
    localparam logic [3:0] OP_BNE    = 4'd6;
    localparam logic [3:0] OP_BNR    = 4'd7;
    localparam logic [3:0] OP_ALU_OP = 4'd8;
    localparam logic [3:0] OP_HLT    = 4'd15;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_BUSY = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sisc_pc_unit.sv
// sisc_pc_unit: program counter register and next-PC selection.
// Ports:
//   clk, rst      clock, async active-high reset (pc <- RESET_PC)
//   pc_rst        synchronous clear to RESET_PC, wins over pc_write
//   pc_write      update enable
//   pc_sel        0 = increment, 1 = branch
//   br_sel        branch kind: 1 = absolute imm, 0 = pc + signed imm
//   imm           16-bit immediate from the instruction register
//   pc            current program counter
// All arithmetic wraps modulo 2^PC_W.
module sisc_pc_unit #(
    parameter int PC_W     = 16,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic [15:0]     imm,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] imm_abs;
    logic [PC_W-1:0] imm_rel;

    // Size casts zero-extend the absolute target and sign-extend the
    // relative offset, truncating either when PC_W is narrower than 16.
    assign imm_abs = PC_W'(imm);
    assign imm_rel = PC_W'($signed(imm));

    always_comb begin
        pc_next = pc;
        if (pc_rst) begin
            pc_next = PC_INIT;
        end else if (pc_write) begin
            if (!pc_sel)
                pc_next = pc + PC_W'(1);
            else if (br_sel)
                pc_next = imm_abs;
            else
                pc_next = pc + imm_rel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= PC_INIT;
        else
            pc <= pc_next;
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: instruction fetch stage of the SISC CPU.
// Holds PC and IR, runs a req/ack handshake with instruction memory and
// abandons a fetch that sees no ack within TIMEOUT busy cycles.
// Ports:
//   clk, rst                 clock, async active-high reset
//   pc_rst, pc_write,
//   pc_sel, br_sel           PC commands from the controller
//   ir_load                  start a fetch at the current pc
//   im_req, im_addr          memory request / address (stable while req)
//   im_ack, im_rdata         memory acknowledge / instruction word
//   pc, ir                   program counter, instruction register
//   opcode, mm, imm          combinational fields of ir
//   if_busy                  fetch outstanding
//   fetch_err                sticky timeout flag, cleared only by rst
//
// state      | meaning
// FETCH_IDLE | no fetch outstanding, waiting for ir_load
// FETCH_BUSY | request asserted, waiting for ack, timeout or pc_rst abort
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int IW       = 32,
    parameter int TIMEOUT  = 15,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    output logic            im_req,
    output logic [PC_W-1:0] im_addr,
    input  logic            im_ack,
    input  logic [IW-1:0]   im_rdata,
    output logic [PC_W-1:0] pc,
    output logic [IW-1:0]   ir,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [15:0]     imm,
    output logic            if_busy,
    output logic            fetch_err
);

    // Last busy cycle before giving up; counter starts at 0 in the first
    // busy cycle, so the fetch lasts TIMEOUT cycles in total.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    fetch_state_e    state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic [IW-1:0]   ir_n;
    logic [PC_W-1:0] addr_n;
    logic            err_n;

    sisc_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .imm      (imm),
        .pc       (pc)
    );

    assign opcode  = ir[OPC_MSB:OPC_LSB];
    assign mm      = ir[MM_MSB:MM_LSB];
    assign imm     = ir[IMM_MSB:IMM_LSB];

    // Decoded straight from the state register so an async rst drops
    // the request in the same instant.
    assign im_req  = (state == FETCH_BUSY);
    assign if_busy = (state == FETCH_BUSY);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ir_n    = ir;
        addr_n  = im_addr;
        err_n   = fetch_err;
        case (state)
            FETCH_IDLE: begin
                if (ir_load) begin
                    // pc is still the pre-update value here even when
                    // pc_write is asserted in the same cycle.
                    addr_n  = pc;
                    cnt_n   = 8'd0;
                    state_n = FETCH_BUSY;
                end
            end
            FETCH_BUSY: begin
                if (pc_rst) begin
                    state_n = FETCH_IDLE;
                end else if (im_ack) begin
                    ir_n    = im_rdata;
                    state_n = FETCH_IDLE;
                end else if (cnt == TO_LAST) begin
                    ir_n    = '0;
                    err_n   = 1'b1;
                    state_n = FETCH_IDLE;
                end else begin
                    cnt_n   = cnt + 8'd1;
                end
            end
            default: state_n = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH_IDLE;
            cnt       <= 8'd0;
            ir        <= '0;
            im_addr   <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ir        <= ir_n;
            im_addr   <= addr_n;
            fetch_err <= err_n;
        end
    end

endmodule
